seg_scan_ctrl: RTL

- Scan controller for the 8-digit seven-segment display.
- Consumes the 480 Hz scan clock from the divider as a plain input level, synchronised into the clk domain.
- Time-multiplexes eight hex digits onto the shared cathode bus, with a blanking gap between digits to stop ghosting.
- Double-buffers display data so a frame never shows a mix of old and new digits (no tearing).

---
 rtl/seg_pkg.sv | 24 ++
 rtl/hex_to_7seg.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Index of the most significant nonzero nibble; 0 when the whole word is zero.
  function automatic logic [DIGIT_W-1:0] top_nonzero(input logic [4*NUM_DIGITS-1:0] d);
    top_nonzero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (d[4*k +: 4] != 4'h0) top_nonzero = DIGIT_W'(k);
    end
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with blanking gaps and a double-buffered shadow.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        led_clk,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        load_ack,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic [2:0]  digit_sel,
  output logic        frame_done
);

  localparam int CNT_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 1) ? BLANK_CYCLES - 1 : 0;

  logic [2:0]         sync_q;
  logic               tick_q;
  scan_state_e        state_q, state_d;
  logic [DIGIT_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [7:0]         sdp_q, sdp_d;
  logic               pending_q, held_q;
  logic               capture, boundary, lz_dark;
  logic [3:0]         nibble_d;
  logic [6:0]         seg_w;
  logic [7:0]         anode_d;

  // Two synchroniser stages, then an edge-detect stage feeding a registered tick.
  // NOTE: every flop uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], led_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    boundary = 1'b0;
    unique case (state_q)
      OFF: begin
        sel_d = '0;
        cnt_d = '0;
        if (load && !held_q) capture = 1'b1;
        if (enable) state_d = BLANK;
      end
      BLANK: begin
        if (!enable) begin
          state_d = OFF;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BLANK_LAST)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_d = OFF;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (tick_q) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = sel_q + DIGIT_W'(1);
          if (sel_q == DIGIT_W'(NUM_DIGITS - 1)) begin
            boundary = 1'b1;
            if (pending_q && load) capture = 1'b1;
          end
        end
      end
      default: begin
        state_d = OFF;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase

    shadow_d = capture ? data_in : shadow_q;
    sdp_d    = capture ? dp_in   : sdp_q;
    nibble_d = shadow_d[{sel_d, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz_dark = (sel_d > top_nonzero(shadow_d)) && !sdp_d[sel_d];
`else
    lz_dark = 1'b0;
`endif

    anode_d = ANODE_OFF;
    if (state_d == DRIVE && digit_en[sel_d] && !lz_dark) anode_d[sel_d] = 1'b0;
  end

  hex_to_7seg u_dec (
    .nibble (nibble_d),
    .seg    (seg_w)
  );

  // Outputs are registered from next-state values so they track the FSM without extra lag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OFF;
      sel_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      sdp_q      <= '0;
      pending_q  <= 1'b0;
      held_q     <= 1'b0;
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
      dp         <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      sdp_q      <= sdp_d;
      pending_q  <= load;
      // A held load in OFF is serviced once; it re-arms when load drops or scanning resumes.
      if (state_q == OFF && capture) held_q <= 1'b1;
      else if (!load || state_d != OFF) held_q <= 1'b0;
      anode      <= anode_d;
      cathode    <= (state_d == DRIVE) ? seg_w : SEG_OFF;
      dp         <= (state_d == DRIVE) ? ~sdp_d[sel_d] : 1'b1;
      load_ack   <= capture;
      frame_done <= boundary;
    end
  end

  assign digit_sel = sel_q;

endmodule
